uart_rx_ctrl: RTL and testbench

Receive control unit for the LCD UART receiver. It synchronizes the raw serial line, detects and validates the start bit, and times mid-bit sampling. It drives the shift strobe into the downstream 9-bit shift register (8 data bits plus the stop bit) and then checks the captured stop bit. It ends each frame with either a one-cycle buffer-load pulse or a framing error.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 33 +++
 rtl/rx_bit_timer.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the LCD UART receive path.
// Imported by the receive control unit and its bit timer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECEIVE,
    CHECK,
    LOAD
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 10;
  localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Line, shift-register and status signals of the UART receive control unit.
// slave is the control unit; master is the line/shift-register side.
interface uart_rx_if;

  logic serial_in;
  logic stop_bit;
  logic serial_sync;
  logic shift_strobe;
  logic load_buffer;
  logic framing_error;
  logic rx_busy;

  modport master (
    output serial_in,
    output stop_bit,
    input  serial_sync,
    input  shift_strobe,
    input  load_buffer,
    input  framing_error,
    input  rx_busy
  );

  modport slave (
    input  serial_in,
    input  stop_bit,
    output serial_sync,
    output shift_strobe,
    output load_buffer,
    output framing_error,
    output rx_busy
  );

endinterface

// File: rtl/rx_bit_timer.sv
// Bit-period clock counter with clear, enable and runtime rollover value.
// tc flags the cycle in which the count equals the rollover value.
module rx_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == max_val);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: line synchronizer, start-bit check, mid-bit
// shift strobes, stop-bit check and buffer-load / framing-error result.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input logic    clk,
  input logic    n_rst,
  uart_rx_if.slave rx
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 2);
  localparam int HALF = CLKS_PER_BIT / 2;

  rx_state_t state, nxt;

  logic          sync1, sync2, prev;
  logic          start_edge;
  logic          t_clr, t_en, t_tc;
  logic [CW-1:0] t_max, t_cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_clr, bit_inc;
  logic          fe, fe_set, fe_clr;
  logic          strobe, load;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx.serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign start_edge = prev & ~sync2;

  rx_bit_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (t_clr),
    .en      (t_en),
    .max_val (t_max),
    .count   (t_cnt),
    .tc      (t_tc)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      fe      <= 1'b0;
    end else begin
      state <= nxt;
      if (bit_clr) bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
      if (fe_clr) fe <= 1'b0;
      else if (fe_set) fe <= 1'b1;
    end
  end

  always_comb begin
    nxt     = state;
    t_clr   = 1'b0;
    t_en    = 1'b0;
    t_max   = CW'(CLKS_PER_BIT - 1);
    bit_clr = 1'b0;
    bit_inc = 1'b0;
    fe_set  = 1'b0;
    fe_clr  = 1'b0;
    strobe  = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        t_clr = 1'b1;
        if (start_edge) nxt = START_CHK;
      end
      START_CHK: begin
        t_en  = 1'b1;
        t_max = CW'(HALF - 1);
        if (t_tc) begin
          t_clr = 1'b1;
          if (!sync2) begin
            nxt     = RECEIVE;
            bit_clr = 1'b1;
            fe_clr  = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end
      end
      RECEIVE: begin
        t_en = 1'b1;
        if (t_tc) begin
          strobe  = 1'b1;
          bit_inc = 1'b1;
          if (bit_cnt == BW'(DATA_BITS)) nxt = CHECK;
        end
      end
      // Stop bit has been shifted in on the previous strobe edge.
      CHECK: begin
        t_clr = 1'b1;
        if (rx.stop_bit) begin
          nxt = LOAD;
        end else begin
          fe_set = 1'b1;
          nxt    = IDLE;
        end
      end
      LOAD: begin
        t_clr = 1'b1;
        load  = 1'b1;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign rx.serial_sync   = sync2;
  assign rx.shift_strobe  = strobe;
  assign rx.load_buffer   = load;
  assign rx.framing_error = fe;
  assign rx.rx_busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural 9-bit shift register
// standing in for the downstream datapath.
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_if bus ();

  uart_rx_ctrl #(
    .CLKS_PER_BIT (10),
    .DATA_BITS    (8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] sr = '1;
  always @(posedge clk)
    if (bus.shift_strobe) sr <= {bus.serial_sync, sr[8:1]};
  assign bus.stop_bit = sr[8];

  int         strobe_log[$];
  int         rise_log[$];
  logic [7:0] data_log[$];
  int         busy_n = 0;
  logic       busy_q = 1'b0;

  always @(negedge clk) begin
    if (bus.shift_strobe) strobe_log.push_back(cyc);
    if (bus.load_buffer) data_log.push_back(sr[7:0]);
    if (bus.rx_busy) busy_n++;
    if (bus.rx_busy && !busy_q) rise_log.push_back(cyc);
    busy_q = bus.rx_busy;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    bus.serial_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rest(input logic [7:0] d, input logic stop);
    for (int i = 0; i < 8; i++) drive(d[i], 10);
    drive(stop, 10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive(1'b0, 10);
    send_rest(d, stop);
  endtask

  function automatic int bad_gaps(input int base, input int n);
    int bad = 0;
    for (int i = 1; i < n; i++)
      if (strobe_log[base+i] - strobe_log[base+i-1] != 10) bad++;
    return bad;
  endfunction

  int s0, l0, r0, b0;

  initial begin
    bus.serial_in = 1'b0;
    n_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sync", int'(bus.serial_sync), 1);
    chk("rst_strobe", int'(bus.shift_strobe), 0);
    chk("rst_load", int'(bus.load_buffer), 0);
    chk("rst_fe", int'(bus.framing_error), 0);
    chk("rst_busy", int'(bus.rx_busy), 0);
    n_rst = 1'b1;
    drive(1'b1, 20);
    chk("idle_no_busy", rise_log.size(), 0);
    chk("idle_no_strobe", strobe_log.size(), 0);

    // 0xA5 valid frame
    s0 = strobe_log.size(); l0 = data_log.size(); r0 = rise_log.size();
    send_frame(8'hA5, 1'b1);
    drive(1'b1, 10);
    chk("a5_strobes", strobe_log.size() - s0, 9);
    chk("a5_first", strobe_log[s0] - rise_log[r0] + 1, 15);
    chk("a5_spacing", bad_gaps(s0, 9), 0);
    chk("a5_loads", data_log.size() - l0, 1);
    chk("a5_data", int'(data_log[l0]), 'hA5);
    chk("a5_fe", int'(bus.framing_error), 0);
    chk("a5_idle", int'(bus.rx_busy), 0);

    // glitch shorter than half a bit
    s0 = strobe_log.size(); l0 = data_log.size(); b0 = busy_n;
    drive(1'b0, 3);
    drive(1'b1, 15);
    chk("glitch_strobes", strobe_log.size() - s0, 0);
    chk("glitch_busy", busy_n - b0, 5);
    chk("glitch_loads", data_log.size() - l0, 0);

    // 0x3C with bad stop, line held low afterwards
    s0 = strobe_log.size(); l0 = data_log.size(); r0 = rise_log.size();
    send_frame(8'h3C, 1'b0);
    drive(1'b0, 30);
    chk("fe_strobes", strobe_log.size() - s0, 9);
    chk("fe_loads", data_log.size() - l0, 0);
    chk("fe_set", int'(bus.framing_error), 1);
    chk("fe_no_restart", rise_log.size() - r0, 1);
    drive(1'b1, 20);
    chk("fe_sticky", int'(bus.framing_error), 1);
    l0 = data_log.size();
    drive(1'b0, 10);
    chk("fe_clear", int'(bus.framing_error), 0);
    send_rest(8'h81, 1'b1);
    drive(1'b1, 10);
    chk("x81_loads", data_log.size() - l0, 1);
    chk("x81_data", int'(data_log[l0]), 'h81);
    chk("x81_fe", int'(bus.framing_error), 0);

    // back-to-back 0x00, 0xFF
    s0 = strobe_log.size(); l0 = data_log.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive(1'b1, 10);
    chk("b2b_strobes", strobe_log.size() - s0, 18);
    chk("b2b_spacing", bad_gaps(s0, 9) + bad_gaps(s0 + 9, 9), 0);
    chk("b2b_loads", data_log.size() - l0, 2);
    chk("b2b_data0", int'(data_log[l0]), 'h00);
    chk("b2b_data1", int'(data_log[l0+1]), 'hFF);
    chk("b2b_fe", int'(bus.framing_error), 0);

    // reset after 4th strobe
    s0 = strobe_log.size(); l0 = data_log.size();
    drive(1'b0, 10);
    for (int i = 0; i < 4; i++) drive(i[0], 10);
    chk("mid_pre_strobes", strobe_log.size() - s0, 4);
    n_rst = 1'b0;
    drive(1'b1, 1);
    n_rst = 1'b1;
    chk("mid_rst_busy", int'(bus.rx_busy), 0);
    drive(1'b1, 120);
    chk("mid_strobes", strobe_log.size() - s0, 4);
    chk("mid_loads", data_log.size() - l0, 0);

    s0 = strobe_log.size(); l0 = data_log.size();
    send_frame(8'h5A, 1'b1);
    drive(1'b1, 10);
    chk("x5a_strobes", strobe_log.size() - s0, 9);
    chk("x5a_loads", data_log.size() - l0, 1);
    chk("x5a_data", int'(data_log[l0]), 'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
